// File: rtl/usb_in_arb_pkg.sv
// Shared state encodings, default widths and grant bit positions for the USB IN arbiter.
package usb_in_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned LEN_W_DEF  = 10;

    localparam int unsigned GNT_A_IDX = 0;
    localparam int unsigned GNT_B_IDX = 1;
    localparam logic [1:0]  GNT_NONE  = 2'b00;
    localparam logic [1:0]  GNT_A     = 2'(1 << GNT_A_IDX);
    localparam logic [1:0]  GNT_B     = 2'(1 << GNT_B_IDX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

endpackage

// File: rtl/usb_in_rr_pick.sv
// Two-way round-robin selector: the requester that did not own last wins a tie.
module usb_in_rr_pick
    import usb_in_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic [1:0] pick_c
);

    always_comb begin
        pick_c = GNT_NONE;
        if (req == (GNT_A | GNT_B)) begin
            pick_c = (last_owner == OWNER_B) ? GNT_A : GNT_B;
        end else begin
            pick_c = req;
        end
    end

endmodule

// File: rtl/usb_in_arbiter.sv
// Whole-packet round-robin arbiter sharing one USB bulk IN endpoint between two loggers.
// Optional per-requester packet counters are built when USB_IN_ARB_STATS_EN is defined.
module usb_in_arbiter
    import usb_in_arb_pkg::*;
#(
    parameter int unsigned HOLD_TIMEOUT = 4096,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned LEN_W        = LEN_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_a_request,
    output logic              req_a_ready,
    input  logic [ADDR_W-1:0] req_a_addr,
    input  logic [7:0]        req_a_data,
    input  logic              req_a_wren,
    input  logic              req_a_commit,
    input  logic [LEN_W-1:0]  req_a_commit_len,
    output logic              req_a_commit_ack,
    input  logic              req_b_request,
    output logic              req_b_ready,
    input  logic [ADDR_W-1:0] req_b_addr,
    input  logic [7:0]        req_b_data,
    input  logic              req_b_wren,
    input  logic              req_b_commit,
    input  logic [LEN_W-1:0]  req_b_commit_len,
    output logic              req_b_commit_ack,
    output logic [ADDR_W-1:0] usb_in_addr,
    output logic [7:0]        usb_in_data,
    output logic              usb_in_wren,
    input  logic              usb_in_ready,
    output logic              usb_in_commit,
    output logic [LEN_W-1:0]  usb_in_commit_len,
    input  logic              usb_in_commit_ack,
`ifdef USB_IN_ARB_STATS_EN
    output logic [31:0]       pkt_count_a,
    output logic [31:0]       pkt_count_b,
`endif
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = (HOLD_TIMEOUT == 0) ? 1 : $clog2(HOLD_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    owner_e            last_owner_q, last_owner_d;
    logic              ack_seen_q, ack_seen_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d, wd_inc;
    logic              timeout_q, timeout_d;
    logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_wren_q, out_wren_d;
    logic              out_commit_q, out_commit_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;

    logic              owner_is_b, fwd;
    logic [1:0]        pick_c;
    logic [ADDR_W-1:0] own_addr;
    logic [7:0]        own_data;
    logic              own_wren, own_commit;
    logic [LEN_W-1:0]  own_len;

    usb_in_rr_pick u_pick (
        .req        ({req_b_request, req_a_request}),
        .last_owner (last_owner_q),
        .pick_c     (pick_c)
    );

    // Owner-side mux; only meaningful while a grant is held.
    assign owner_is_b = (grant_q == GNT_B);
    assign own_addr   = owner_is_b ? req_b_addr       : req_a_addr;
    assign own_data   = owner_is_b ? req_b_data       : req_a_data;
    assign own_wren   = owner_is_b ? req_b_wren       : req_a_wren;
    assign own_commit = owner_is_b ? req_b_commit     : req_a_commit;
    assign own_len    = owner_is_b ? req_b_commit_len : req_a_commit_len;
    assign wd_inc     = wd_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        ack_seen_d   = ack_seen_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        fwd          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (usb_in_ready && (pick_c != GNT_NONE)) begin
                    grant_d    = pick_c;
                    state_d    = ST_GRANT;
                    wd_cnt_d   = '0;
                    ack_seen_d = 1'b0;
                end
            end
            ST_GRANT: begin
                fwd = 1'b1;
                if (own_commit) begin
                    state_d  = ST_COMMIT;
                    wd_cnt_d = '0;
                end else if (own_wren) begin
                    wd_cnt_d = '0;
                end else if (HOLD_TIMEOUT != 0) begin
                    wd_cnt_d = wd_inc;
                    // Silent owner: drop it without committing, discarding the partial buffer.
                    if (wd_inc == CNT_W'(HOLD_TIMEOUT)) begin
                        fwd          = 1'b0;
                        timeout_d    = 1'b1;
                        grant_d      = GNT_NONE;
                        last_owner_d = owner_is_b ? OWNER_B : OWNER_A;
                        state_d      = ST_RELEASE;
                    end
                end
            end
            ST_COMMIT: begin
                fwd     = 1'b1;
                ack_a_d = usb_in_commit_ack && !owner_is_b;
                ack_b_d = usb_in_commit_ack && owner_is_b;
                if (usb_in_commit_ack) begin
                    ack_seen_d = 1'b1;
                end else if (ack_seen_q && !own_commit) begin
                    fwd          = 1'b0;
                    grant_d      = GNT_NONE;
                    last_owner_d = owner_is_b ? OWNER_B : OWNER_A;
                    state_d      = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_addr_d   = fwd ? own_addr   : '0;
        out_data_d   = fwd ? own_data   : '0;
        out_wren_d   = fwd && own_wren;
        out_commit_d = fwd && own_commit;
        out_len_d    = fwd ? own_len    : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            last_owner_q <= OWNER_B;
            ack_seen_q   <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_wren_q   <= 1'b0;
            out_commit_q <= 1'b0;
            out_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            ack_seen_q   <= ack_seen_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_wren_q   <= out_wren_d;
            out_commit_q <= out_commit_d;
            out_len_q    <= out_len_d;
        end
    end

`ifdef USB_IN_ARB_STATS_EN
    logic        commit_done_c;
    logic [31:0] pkt_cnt_a_q, pkt_cnt_a_d, pkt_cnt_b_q, pkt_cnt_b_d;

    // Only a completed commit counts; watchdog releases leave the counters alone.
    always_comb begin
        commit_done_c = (state_q == ST_COMMIT) && (state_d == ST_RELEASE);
        pkt_cnt_a_d   = pkt_cnt_a_q;
        pkt_cnt_b_d   = pkt_cnt_b_q;
        if (commit_done_c && owner_is_b) begin
            pkt_cnt_b_d = pkt_cnt_b_q + 32'd1;
        end else if (commit_done_c) begin
            pkt_cnt_a_d = pkt_cnt_a_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_a_q <= '0;
            pkt_cnt_b_q <= '0;
        end else begin
            pkt_cnt_a_q <= pkt_cnt_a_d;
            pkt_cnt_b_q <= pkt_cnt_b_d;
        end
    end

    assign pkt_count_a = pkt_cnt_a_q;
    assign pkt_count_b = pkt_cnt_b_q;
`endif

    assign grant             = grant_q;
    assign timeout_err       = timeout_q;
    assign req_a_ready       = (grant_q == GNT_A) && usb_in_ready;
    assign req_b_ready       = (grant_q == GNT_B) && usb_in_ready;
    assign req_a_commit_ack  = ack_a_q;
    assign req_b_commit_ack  = ack_b_q;
    assign usb_in_addr       = out_addr_q;
    assign usb_in_data       = out_data_q;
    assign usb_in_wren       = out_wren_q;
    assign usb_in_commit     = out_commit_q;
    assign usb_in_commit_len = out_len_q;

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed scoreboard bench for usb_in_arbiter (watchdog shortened to 16 idle cycles).
module tb_usb_in_arbiter;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned HOLD   = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              wren;
        logic              commit;
        logic [LEN_W-1:0]  len;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_a_request, req_a_ready, req_a_wren, req_a_commit, req_a_commit_ack;
    logic [ADDR_W-1:0] req_a_addr;
    logic [7:0]        req_a_data;
    logic [LEN_W-1:0]  req_a_commit_len;
    logic              req_b_request, req_b_ready, req_b_wren, req_b_commit, req_b_commit_ack;
    logic [ADDR_W-1:0] req_b_addr;
    logic [7:0]        req_b_data;
    logic [LEN_W-1:0]  req_b_commit_len;
    logic [ADDR_W-1:0] usb_in_addr;
    logic [7:0]        usb_in_data;
    logic              usb_in_wren, usb_in_ready, usb_in_commit, usb_in_commit_ack;
    logic [LEN_W-1:0]  usb_in_commit_len;
    logic [1:0]        grant;
    logic              timeout_err;
    logic              ep_ack_force;
`ifdef USB_IN_ARB_STATS_EN
    logic [31:0]       pkt_count_a, pkt_count_b;
`endif

    int    n_checks = 0;
    int    n_pass   = 0;
    beat_t sb[$];

    always #5 clock = ~clock;

    // Endpoint model: acknowledges a commit for as long as it is presented.
    assign usb_in_commit_ack = usb_in_commit | ep_ack_force;

    usb_in_arbiter #(.HOLD_TIMEOUT(HOLD), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_a_request     (req_a_request),
        .req_a_ready       (req_a_ready),
        .req_a_addr        (req_a_addr),
        .req_a_data        (req_a_data),
        .req_a_wren        (req_a_wren),
        .req_a_commit      (req_a_commit),
        .req_a_commit_len  (req_a_commit_len),
        .req_a_commit_ack  (req_a_commit_ack),
        .req_b_request     (req_b_request),
        .req_b_ready       (req_b_ready),
        .req_b_addr        (req_b_addr),
        .req_b_data        (req_b_data),
        .req_b_wren        (req_b_wren),
        .req_b_commit      (req_b_commit),
        .req_b_commit_len  (req_b_commit_len),
        .req_b_commit_ack  (req_b_commit_ack),
        .usb_in_addr       (usb_in_addr),
        .usb_in_data       (usb_in_data),
        .usb_in_wren       (usb_in_wren),
        .usb_in_ready      (usb_in_ready),
        .usb_in_commit     (usb_in_commit),
        .usb_in_commit_len (usb_in_commit_len),
        .usb_in_commit_ack (usb_in_commit_ack),
`ifdef USB_IN_ARB_STATS_EN
        .pkt_count_a       (pkt_count_a),
        .pkt_count_b       (pkt_count_b),
`endif
        .grant             (grant),
        .timeout_err       (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; compare the endpoint beat expected for this cycle, if any.
    task automatic cycle();
        beat_t e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("usb_beat", 64'({usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len}),
                64'(e));
        end
    endtask

    task automatic drive(input bit who_b, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                         input logic w, input logic c, input logic [LEN_W-1:0] l, input bit push);
        beat_t e;
        if (who_b) begin
            req_b_addr = a; req_b_data = d; req_b_wren = w; req_b_commit = c; req_b_commit_len = l;
        end else begin
            req_a_addr = a; req_a_data = d; req_a_wren = w; req_a_commit = c; req_a_commit_len = l;
        end
        if (push) begin
            e.addr = a; e.data = d; e.wren = w; e.commit = c; e.len = l;
            sb.push_back(e);
        end
    endtask

    task automatic clear_inputs();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_grant(input logic [1:0] exp, input int max_c, input string tag);
        for (int i = 0; i < max_c; i++) begin
            if (grant == exp) break;
            cycle();
        end
        chk(tag, 64'(grant), 64'(exp));
    endtask

    task automatic commit_release(input bit who_b, input logic [LEN_W-1:0] len);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(who_b, '0, '0, 1'b0, 1'b1, len, 1'b1);
            cycle();
            got = who_b ? req_b_commit_ack : req_a_commit_ack;
            if (got) break;
        end
        chk("commit_ack", 64'(got), 64'(1));
        drive(who_b, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        cycle();
        wait_grant(2'b00, 4, "release");
    endtask

    task automatic send_pkt(input bit who_b, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive(who_b, ADDR_W'(base + i), 8'(base * 3 + i), 1'b1, 1'b0, '0, 1'b1);
            cycle();
        end
        commit_release(who_b, LEN_W'(n));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_a_request = 1'b0;
        req_b_request = 1'b0;
        clear_inputs();
        sb.delete();
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        usb_in_ready  = 1'b1;
        ep_ack_force  = 1'b0;
        req_a_request = 1'b0;
        req_b_request = 1'b0;
        clear_inputs();
        #2;
        chk("reset_outputs", 64'({grant, timeout_err, usb_in_commit, usb_in_wren, usb_in_addr,
                                  usb_in_data, usb_in_commit_len, req_a_ready, req_b_ready,
                                  req_a_commit_ack, req_b_commit_ack}), 64'(0));
        do_reset();

        // Single A packet: 12 writes mirrored one cycle late, commit_len 12.
        chk("idle_grant", 64'(grant), 64'(2'b00));
        req_a_request = 1'b1;
        cycle();
        chk("grant_a_first", 64'(grant), 64'(2'b01));
        chk("ready_gating", 64'({req_a_ready, req_b_ready}), 64'(2'b10));
        send_pkt(1'b0, 12, 64);
        chk("post_release", 64'({usb_in_wren, usb_in_commit, req_a_commit_ack}), 64'(0));
        req_a_request = 1'b0;

        // Both request from reset: strict alternation A,B,A,B,A,B.
        do_reset();
        req_a_request = 1'b1;
        req_b_request = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_grant((r % 2 == 0) ? 2'b01 : 2'b10, 8, "rr_order");
            send_pkt(r % 2 == 1, 2, 16 * r);
            cycle();
            chk("dead_cycle", 64'(grant), 64'(2'b00));
        end
        req_a_request = 1'b0;
        req_b_request = 1'b0;
        cycle();

        // B arrives mid-packet: blocked until A releases; A drops request but keeps the grant.
        req_a_request = 1'b1;
        wait_grant(2'b01, 4, "grant_a_mid");
        req_a_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ADDR_W'(9'h100 + i), 8'(8'h50 + i), 1'b1, 1'b0, '0, 1'b1);
            cycle();
        end
        req_b_request = 1'b1;
        drive(1'b1, 9'h1FF, 8'hEE, 1'b1, 1'b0, 10'h3FF, 1'b0);
        for (int i = 3; i < 6; i++) begin
            drive(1'b0, ADDR_W'(9'h100 + i), 8'(8'h50 + i), 1'b1, 1'b0, '0, 1'b1);
            cycle();
            chk("b_ready_blocked", 64'({req_b_ready, grant}), 64'({1'b0, 2'b01}));
        end
        commit_release(1'b0, 10'd6);
        cycle();
        chk("b_wait_dead", 64'(grant), 64'(2'b00));
        cycle();
        chk("b_after_release", 64'(grant), 64'(2'b10));
        send_pkt(1'b1, 2, 200);
        req_b_request = 1'b0;
        clear_inputs();

        // Endpoint not ready: no grant until usb_in_ready rises.
        usb_in_ready  = 1'b0;
        req_a_request = 1'b1;
        req_b_request = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("not_ready", 64'(grant), 64'(2'b00));
        end
        usb_in_ready = 1'b1;
        cycle();
        chk("grant_after_ready", 64'(grant), 64'(2'b01));
        req_b_request = 1'b0;
        usb_in_ready  = 1'b0;
        #1;
        chk("ready_follow_lo", 64'(req_a_ready), 64'(0));
        usb_in_ready = 1'b1;
        #1;
        chk("ready_follow_hi", 64'(req_a_ready), 64'(1));
        ep_ack_force = 1'b1;
        cycle();
        chk("ack_ignored", 64'({grant, req_a_commit_ack}), 64'({2'b01, 1'b0}));
        ep_ack_force = 1'b0;
        send_pkt(1'b0, 2, 300);
        req_a_request = 1'b0;
        cycle();

        // Watchdog: A granted and silent for 16 cycles is dropped; B then served.
        req_a_request = 1'b1;
        wait_grant(2'b01, 4, "wd_grant");
        req_b_request = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("wd_hold", 64'({grant, timeout_err}), 64'({2'b01, 1'b0}));
            cycle();
        end
        chk("wd_fire", 64'({grant, timeout_err, usb_in_commit}), 64'({2'b00, 1'b1, 1'b0}));
        cycle();
        chk("wd_pulse_end", 64'({timeout_err, usb_in_commit}), 64'(0));
        req_a_request = 1'b0;
        wait_grant(2'b10, 6, "b_after_timeout");
        send_pkt(1'b1, 1, 400);
        req_b_request = 1'b0;
        cycle();

        // Asynchronous reset mid-COMMIT, then A regains first priority.
        req_a_request = 1'b1;
        wait_grant(2'b01, 4, "grant_pre_reset");
        drive(1'b0, 9'h010, 8'h11, 1'b1, 1'b0, '0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 10'd1, 1'b1);
        cycle();
        reset_n = 1'b0;
        #1;
        chk("async_reset", 64'({grant, timeout_err, usb_in_commit, usb_in_wren, usb_in_addr,
                                usb_in_data, usb_in_commit_len, req_a_ready, req_b_ready,
                                req_a_commit_ack, req_b_commit_ack}), 64'(0));
        do_reset();
        req_a_request = 1'b1;
        req_b_request = 1'b1;
        wait_grant(2'b01, 4, "prio_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_in_arbiter.md
Name: usb_in_arbiter

Overview:
- Shares one USB bulk IN endpoint buffer between two packet loggers (e.g. GMII RX and TX loggers).
- Grants whole packets: a requester owns the endpoint from grant until its commit handshake completes.
- Uses round-robin priority between requesters. Sits between the loggers and the USB IN endpoint buffer/commit logic.

Parameters:
HOLD_TIMEOUT, 4096, idle cycles (no wren, no commit) a granted requester may hold before forced release; 0 disables the watchdog.
ADDR_W, 9, endpoint buffer address width.
LEN_W, 10, commit length width.

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
req_a_request  in  1  requester A has a packet pending
req_a_ready  out  1  endpoint ready, gated to A's grant
req_a_addr  in  ADDR_W  A buffer address
req_a_data  in  8  A write data
req_a_wren  in  1  A write enable
req_a_commit  in  1  A commit request
req_a_commit_len  in  LEN_W  A commit length
req_a_commit_ack  out  1  commit ack routed to A
req_b_*  same set as req_a_*, for requester B
usb_in_addr  out  ADDR_W  to endpoint
usb_in_data  out  8  to endpoint
usb_in_wren  out  1  to endpoint
usb_in_ready  in  1  endpoint buffer free
usb_in_commit  out  1  to endpoint
usb_in_commit_len  out  LEN_W  to endpoint
usb_in_commit_ack  in  1  from endpoint
grant  out  2  one-hot current owner (bit0=A)
timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; every output 0; last_owner=B, so A has first priority.
- FSM states: IDLE, GRANT, COMMIT, RELEASE.
- IDLE, usb_in_ready=1, any request: grant the requester that is not last_owner; if only one requests, grant it. Set grant, go to GRANT. No grant while usb_in_ready=0.
- GRANT: owner's req_X_ready follows usb_in_ready combinationally. Non-owner ready=0 and commit_ack=0.
- GRANT datapath: owner's addr/data/wren/commit/commit_len are registered onto usb_in_*, 1-cycle latency, all fields aligned. Non-owner inputs are ignored.
- GRANT exit: owner commit=1 -> COMMIT.
- COMMIT: keep forwarding owner commit/commit_len (registered). req_X_commit_ack = usb_in_commit_ack registered (1 cycle). When usb_in_commit_ack=0 and owner commit=0 after an ack was seen -> RELEASE.
- RELEASE: clear grant, last_owner=owner, usb_in_* driven 0. Next cycle IDLE. Minimum 1 dead cycle between packets.
- Requests arriving mid-packet from the non-owner wait. A requester dropping request while granted does not release the grant; only commit completion or the watchdog releases it.
- Watchdog: counter (width clog2(HOLD_TIMEOUT+1)) clears on owner wren or commit. Reaching HOLD_TIMEOUT in GRANT -> timeout_err pulse, RELEASE. No commit is issued, so the partial buffer is discarded.
- usb_in_commit_ack asserted in IDLE/GRANT is ignored.

Optional Feature:
USB_IN_ARB_STATS_EN
- Defined: adds outputs pkt_count_a and pkt_count_b (32 bits each). A counter increments on entry to RELEASE via a completed commit; watchdog releases do not count. Counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package usb_in_arb_pkg: state encodings (IDLE=0, GRANT=1, COMMIT=2, RELEASE=3), ADDR_W/LEN_W defaults, grant bit indices.
- One sub-module, usb_in_rr_pick: 2-way round-robin selector. Inputs: requests, last_owner. Output: one-hot pick. Purely combinational.

Test Plan:
- Single A packet: A requests, ready=1, 12 writes, commit_len=12 -> grant=01 next cycle; usb_in_* mirrors A one cycle late; usb_in_commit_len=12; A sees ack; grant=00 after RELEASE.
- Simultaneous A and B after reset -> A served first, then B. Three back-to-back rounds alternate A,B,A,B,A,B.
- B requests while A is mid-packet -> B ready stays 0 and B writes never reach usb_in_wren; B is granted one cycle after A's RELEASE.
- usb_in_ready=0 with requests pending -> grant stays 00; grant issues on the cycle after ready rises.
- HOLD_TIMEOUT=16, A granted then silent -> timeout_err pulse at idle cycle 16; no usb_in_commit; B is granted next if requesting.
- Assert reset_n low mid-COMMIT -> all outputs 0 immediately, no clock needed; after release, A has priority again.
